// File: rtl/cla_bist.sv
// cla_bist: exhaustive on-chip self-test driver/checker for the registered CLA.
// Optional first-failure capture ports: define CLA_BIST_FIRSTFAIL_EN.
module cla_bist #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1,
  parameter int ERR_W = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Cin,
  input  logic [WIDTH-1:0] S,
  input  logic             C4,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] ErrCount
`ifdef CLA_BIST_FIRSTFAIL_EN
  ,
  output logic [2*WIDTH:0] FailVec,
  output logic [WIDTH:0]   FailObs
`endif
);

  localparam int VW = 2*WIDTH+1;
  localparam int SW = WIDTH+1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [VW-1:0]    r_vec;
  logic [2:0]       r_drn;
  logic             r_dl_v   [LAT];
  logic [SW-1:0]    r_dl_exp [LAT];
`ifdef CLA_BIST_FIRSTFAIL_EN
  logic [VW-1:0]    r_dl_vec [LAT];
`endif

  logic             w_start;
  logic             w_last;
  logic             w_drn_end;
  logic [SW-1:0]    w_exp;
  logic [SW-1:0]    w_obs;
  logic             w_mis;
  logic [ERR_W-1:0] w_err_nxt;

  assign {Cin, A, B} = r_vec;
  assign Busy      = (r_state == RUN) || (r_state == DRAIN);
  assign w_start   = Start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_vec == {VW{1'b1}});
  assign w_drn_end = (r_drn == 3'(LAT-1));
  assign w_exp     = {1'b0, r_vec[VW-2:WIDTH]}
                   + {1'b0, r_vec[WIDTH-1:0]}
                   + SW'(r_vec[VW-1]);
  assign w_obs     = {C4, S};
  assign w_mis     = r_dl_v[LAT-1] && (w_obs != r_dl_exp[LAT-1]);

  // error count: clear on restart, saturating increment on mismatch
  always_comb begin
    w_err_nxt = ErrCount;
    if (w_start)
      w_err_nxt = '0;
    else if (w_mis && (ErrCount != {ERR_W{1'b1}}))
      w_err_nxt = ErrCount + ERR_W'(1);
  end

  // sweep sequencing: idle -> issue vectors -> drain pipeline -> report
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Start)     w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DRAIN;
      DRAIN:   if (w_drn_end) w_state_nxt = DONE;
      DONE:    if (Start)     w_state_nxt = RUN;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // state, vector counter, drain counter and result registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= IDLE;
      r_vec    <= '0;
      r_drn    <= '0;
      ErrCount <= '0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec    <= (r_state == RUN && !w_last) ? r_vec + VW'(1) : '0;
      r_drn    <= (r_state == DRAIN) ? r_drn + 3'd1 : 3'd0;
      ErrCount <= w_err_nxt;
      if (w_start) begin
        Done <= 1'b0;
        Pass <= 1'b0;
      end else if (r_state == DRAIN && w_drn_end) begin
        Done <= 1'b1;
        Pass <= (w_err_nxt == '0);
      end
    end
  end

  // expected-result delay line aligned to the adder latency
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_dl_v[i]   <= 1'b0;
        r_dl_exp[i] <= '0;
      end
    end else begin
      r_dl_v[0]   <= (r_state == RUN);
      r_dl_exp[0] <= w_exp;
      for (int i = 1; i < LAT; i++) begin
        r_dl_v[i]   <= r_dl_v[i-1];
        r_dl_exp[i] <= r_dl_exp[i-1];
      end
    end
  end

`ifdef CLA_BIST_FIRSTFAIL_EN
  // issued-vector delay line and first-mismatch capture
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < LAT; i++)
        r_dl_vec[i] <= '0;
      FailVec <= '0;
      FailObs <= '0;
    end else begin
      r_dl_vec[0] <= r_vec;
      for (int i = 1; i < LAT; i++)
        r_dl_vec[i] <= r_dl_vec[i-1];
      if (w_start) begin
        FailVec <= '0;
        FailObs <= '0;
      end else if (w_mis && ErrCount == '0) begin
        FailVec <= r_dl_vec[LAT-1];
        FailObs <= w_obs;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cla_bist.sv
// tb_cla_bist: directed checks of cla_bist against behavioural adder models.
// Instance u1 uses LAT=1, instance u2 uses LAT=2.
`define CHK(tag, o, e) begin \
  n_cmp++; \
  assert ((o) === (e)) else begin \
    n_err++; \
    $error("FAIL %s: observed %0d expected %0d", tag, (o), (e)); \
  end \
end

module tb_cla_bist;
  localparam int W = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Start1 = 1'b0;
  logic Start2 = 1'b0;

  logic [W-1:0] A1, B1, S1, A2, B2, S2;
  logic Cin1, C41, Busy1, Done1, Pass1;
  logic Cin2, C42, Busy2, Done2, Pass2;
  logic [9:0] Err1, Err2;
`ifdef CLA_BIST_FIRSTFAIL_EN
  logic [2*W:0] FailVec1, FailVec2;
  logic [W:0]   FailObs1, FailObs2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int nb;

  logic lat2_m = 1'b0;
  logic stuck_m = 1'b0;
  logic [W:0] p1, p2, q1, q2, obs1;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    p1 <= {1'b0, A1} + {1'b0, B1} + {4'b0, Cin1};
    p2 <= p1;
    q1 <= {1'b0, A2} + {1'b0, B2} + {4'b0, Cin2};
    q2 <= q1;
  end

  always_comb begin
    obs1 = lat2_m ? p2 : p1;
    if (stuck_m) obs1[0] = 1'b0;
  end

  assign {C41, S1} = obs1;
  assign {C42, S2} = q2;

  cla_bist #(.WIDTH(W), .LAT(1), .ERR_W(10)) u1 (
    .Clk(Clk), .Rst(Rst), .Start(Start1),
    .A(A1), .B(B1), .Cin(Cin1), .S(S1), .C4(C41),
    .Busy(Busy1), .Done(Done1), .Pass(Pass1), .ErrCount(Err1)
`ifdef CLA_BIST_FIRSTFAIL_EN
    , .FailVec(FailVec1), .FailObs(FailObs1)
`endif
  );

  cla_bist #(.WIDTH(W), .LAT(2), .ERR_W(10)) u2 (
    .Clk(Clk), .Rst(Rst), .Start(Start2),
    .A(A2), .B(B2), .Cin(Cin2), .S(S2), .C4(C42),
    .Busy(Busy2), .Done(Done2), .Pass(Pass2), .ErrCount(Err2)
`ifdef CLA_BIST_FIRSTFAIL_EN
    , .FailVec(FailVec2), .FailObs(FailObs2)
`endif
  );

  task automatic sweep(input bit inst2, input int ign_at,
                       output int n);
    bit fin;
    fin = 1'b0;
    n = 0;
    @(negedge Clk);
    if (inst2) Start2 = 1'b1;
    else Start1 = 1'b1;
    @(negedge Clk);
    Start1 = 1'b0;
    Start2 = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (!(inst2 ? Busy2 : Busy1)) begin
        fin = 1'b1;
        break;
      end
      if (!inst2 && n == 0) begin
        `CHK("entry_done", Done1, 1'b0)
        `CHK("entry_pass", Pass1, 1'b0)
        `CHK("entry_err", Err1, 10'd0)
      end
      if (!inst2 && (n == 1 || n == 255 || n == 511))
        `CHK("vec", {Cin1, A1, B1}, 9'(n))
      Start1 = !inst2 && (n == ign_at);
      n++;
      @(negedge Clk);
    end
    Start1 = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_err++;
      $error("FAIL timeout: Busy still high after 2000 cycles");
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (Busy1 !== 1'b0 || Done1 !== 1'b0 || Pass1 !== 1'b0 ||
        Err1 !== 10'd0 || Busy2 !== 1'b0) begin
      n_err++;
      $error("FAIL reset state: busy %b done %b pass %b err %0d",
             Busy1, Done1, Pass1, Err1);
    end
    `CHK("rst_busy", Busy1, 1'b0)
    `CHK("rst_done", Done1, 1'b0)
    `CHK("rst_pass", Pass1, 1'b0)
    `CHK("rst_err", Err1, 10'd0)
    `CHK("rst_vec", {Cin1, A1, B1}, 9'd0)
    `CHK("rst_busy2", Busy2, 1'b0)
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    `CHK("idle_busy", Busy1, 1'b0)

    // golden adder, LAT=1
    sweep(1'b0, -1, nb);
    `CHK("g_busy_len", nb, 513)
    `CHK("g_done", Done1, 1'b1)
    `CHK("g_pass", Pass1, 1'b1)
    `CHK("g_err", Err1, 10'd0)
    `CHK("g_vec_hold", {Cin1, A1, B1}, 9'd0)

    // S[0] stuck at 0
    stuck_m = 1'b1;
    sweep(1'b0, -1, nb);
    `CHK("s0_busy_len", nb, 513)
    `CHK("s0_done", Done1, 1'b1)
    `CHK("s0_pass", Pass1, 1'b0)
    `CHK("s0_err", Err1, 10'd256)
`ifdef CLA_BIST_FIRSTFAIL_EN
    `CHK("s0_failvec", FailVec1, 9'b0_0000_0001)
    `CHK("s0_failobs", FailObs1, 5'b0_0000)
`endif

    // restart from failed result with golden adder
    stuck_m = 1'b0;
    sweep(1'b0, -1, nb);
    `CHK("re_busy_len", nb, 513)
    `CHK("re_pass", Pass1, 1'b1)
    `CHK("re_err", Err1, 10'd0)
`ifdef CLA_BIST_FIRSTFAIL_EN
    `CHK("re_failvec", FailVec1, 9'd0)
    `CHK("re_failobs", FailObs1, 5'd0)
`endif

    // adder latency 2 checked with LAT=1: every vector after 0 misaligned
    lat2_m = 1'b1;
    sweep(1'b0, -1, nb);
    `CHK("l2_done", Done1, 1'b1)
    `CHK("l2_pass", Pass1, 1'b0)
    `CHK("l2_err", Err1, 10'd511)
    lat2_m = 1'b0;

    // latency 2 adder with LAT=2 checker
    sweep(1'b1, -1, nb);
    `CHK("u2_busy_len", nb, 514)
    `CHK("u2_done", Done2, 1'b1)
    `CHK("u2_pass", Pass2, 1'b1)
    `CHK("u2_err", Err2, 10'd0)

    // Start during RUN is ignored
    sweep(1'b0, 100, nb);
    `CHK("ign_busy_len", nb, 513)
    `CHK("ign_pass", Pass1, 1'b1)

    // reset mid-sweep aborts everything
    stuck_m = 1'b1;
    @(negedge Clk);
    Start1 = 1'b1;
    @(negedge Clk);
    Start1 = 1'b0;
    repeat (200) @(negedge Clk);
    `CHK("mid_err_nz", Err1 != 10'd0, 1'b1)
    Rst = 1'b0;
    #1;
    `CHK("ar_busy", Busy1, 1'b0)
    `CHK("ar_done", Done1, 1'b0)
    `CHK("ar_pass", Pass1, 1'b0)
    `CHK("ar_err", Err1, 10'd0)
    `CHK("ar_vec", {Cin1, A1, B1}, 9'd0)
    @(negedge Clk);
    Rst = 1'b1;
    stuck_m = 1'b0;
    repeat (3) @(negedge Clk);
    `CHK("ar_idle", Busy1, 1'b0)
    sweep(1'b0, -1, nb);
    `CHK("ar_busy_len", nb, 513)
    `CHK("ar_fpass", Pass1, 1'b1)
    `CHK("ar_ferr", Err1, 10'd0)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
